pa_hpcp_cnt: RTL
================

# pa_hpcp_cnt

Event-driven hardware performance counter that consumes the 5-bit event index held by the HPCP event-select register and counts the matching core event pulses. It sits in the PMU beside each event-select register. It exposes a 64-bit count readable and writable as two 32-bit CSR halves, plus a sticky overflow indication.

## Interface
Parameters:
- CNT_WIDTH, 64, counter width; even, 34..64; halves are CNT_WIDTH/2 each.

Ports:
- forever_cpuclk  in  1  core clock.
- cpurst  in  1  asynchronous, active-high reset.
- event_sel  in  5  event index from the event-select register; 0 = no event.
- event_vld  in  32  per-event pulses, one cycle per occurrence; bit 0 ignored.
- cnt_inhibit  in  1  counting inhibit (mcountinhibit bit); writes still allowed.
- cnt_lo_wen  in  1  write low half this cycle.
- cnt_hi_wen  in  1  write high half this cycle.
- hpcp_wdata  in  32  CSR write data; only [CNT_WIDTH/2-1:0] used.
- cnt_value  out  CNT_WIDTH  current count.
- cnt_ovf  out  1  sticky overflow flag (macro-dependent).
- cnt_ovf_int  out  1  one-cycle overflow interrupt pulse (macro-dependent).

## Operation
- Stage 1 (sample): hit = (event_sel != 0) & event_vld[event_sel] & ~cnt_inhibit. Register into event_hit_ff.
  - Reset value of event_hit_ff: 0.
- Stage 2 (count): if event_hit_ff, counter += 1, modulo 2^CNT_WIDTH.
  - The carry from the low half into the high half occurs in the same cycle.
- Writes:
  - cnt_lo_wen loads the low half from hpcp_wdata.
  - cnt_hi_wen loads the high half.
  - Both may assert in one cycle.
- Write/increment collision in the same cycle:
  - A written half takes the written value; the increment to that half is dropped.
  - Lo written, hi not: the high half does not receive a carry.
  - Hi written, lo not: the low half increments normally; any carry out of lo is discarded.
- cnt_inhibit asserting does not cancel an event_hit_ff already captured; that one increment still completes.
- event_sel change takes effect on the event_vld sampled in the same cycle.
- Reset:
  - cnt_value = 0, cnt_ovf = 0, cnt_ovf_int = 0, event_hit_ff = 0.
  - Reset mid-operation discards any pending hit.

## Timing
- event_vld pulse in cycle N: event_hit_ff = 1 in N+1; cnt_value reflects +1 in N+2. Latency is 2 cycles.
- Back-to-back pulses in every cycle yield one increment per cycle; sustained throughput is 1/cycle.
- A write in cycle N is visible on cnt_value in cycle N+1.
- Overflow: an increment from all-ones to 0 in cycle N sets cnt_ovf in N+1 and pulses cnt_ovf_int in N+1 only.
  - A write of all-ones does not set the flag; only an increment wrap does.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- PA_HPCP_CNT_OVF_EN defined:
  - cnt_ovf is a sticky flag; cleared by cnt_hi_wen.
  - If a wrap and cnt_hi_wen occur in the same cycle, the wrap loses: the flag is cleared.
  - cnt_ovf_int pulses as described in Timing.
- PA_HPCP_CNT_OVF_EN undefined:
  - No overflow logic; cnt_ovf and cnt_ovf_int are tied 0.
  - The counter still wraps silently.

## Test plan
- Reset mid-count: run events, assert cpurst → cnt_value = 0, cnt_ovf = 0 immediately; the first event after release gives cnt_value = 1 two cycles later.
- event_sel = 5, event_vld[5] high for 4 consecutive cycles, event_vld[6] toggling → cnt_value steps 0→1→2→3→4 starting 2 cycles after the first pulse; event_sel = 0 → no counts.
- Carry: write lo = 0xFFFF_FFFF, hi = 0x0000_0001; one event → cnt_value = 0x0000_0002_0000_0000.
- Collision: event_hit_ff = 1 while cnt_lo_wen writes 0x10 with lo previously 0xFFFF_FFFF → lo = 0x10, hi unchanged.
- Inhibit: cnt_inhibit high with continuous events → no increments after the one already in flight; a lo write of 0x55 → cnt_value low = 0x55 next cycle.
- Overflow (macro on): preset all-ones, one event → cnt_value = 0, cnt_ovf = 1, cnt_ovf_int high for exactly 1 cycle; a hi write clears cnt_ovf. With the macro off, both outputs stay 0.

Source files
------------

// File: rtl/pa_hpcp_cnt_if.sv
// pa_hpcp_cnt_if: groups the event-select, CSR-write and count-readback
// signals of one HPCP performance counter.
// master = PMU/CSR side driving events and writes; slave = the counter.
interface pa_hpcp_cnt_if #(
  parameter int CNT_WIDTH = 64
) ();
  logic [4:0]           event_sel;
  logic [31:0]          event_vld;
  logic                 cnt_inhibit;
  logic                 cnt_lo_wen;
  logic                 cnt_hi_wen;
  logic [31:0]          hpcp_wdata;
  logic [CNT_WIDTH-1:0] cnt_value;
  logic                 cnt_ovf;
  logic                 cnt_ovf_int;

  modport master (
    output event_sel, event_vld, cnt_inhibit, cnt_lo_wen, cnt_hi_wen, hpcp_wdata,
    input  cnt_value, cnt_ovf, cnt_ovf_int
  );

  modport slave (
    input  event_sel, event_vld, cnt_inhibit, cnt_lo_wen, cnt_hi_wen, hpcp_wdata,
    output cnt_value, cnt_ovf, cnt_ovf_int
  );
endinterface

// File: rtl/pa_hpcp_cnt.sv
// pa_hpcp_cnt: event-driven hardware performance counter.
// Stage 1 samples the selected event pulse into event_hit_q; stage 2 adds it
// to a counter split into two CSR-writable halves. Writes override the
// increment of the half they target.
// Optional feature: define PA_HPCP_CNT_OVF_EN to build the sticky overflow
// flag and its one-cycle interrupt pulse; otherwise both outputs are tied 0
// and the counter wraps silently.
module pa_hpcp_cnt #(
  parameter int CNT_WIDTH = 64
) (
  input logic             forever_cpuclk,
  input logic             cpurst,
  pa_hpcp_cnt_if.slave    hpcp
);

  localparam int HW = CNT_WIDTH / 2;

  logic          event_hit_d, event_hit_q;
  logic [HW-1:0] cnt_lo_d, cnt_lo_q;
  logic [HW-1:0] cnt_hi_d, cnt_hi_q;
  logic [HW:0]   lo_sum;
  logic          lo_carry;
  logic [HW-1:0] hi_inc;

  // Stage 1: qualify the selected event pulse; index 0 means "no event".
  always_comb begin
    event_hit_d = (hpcp.event_sel != 5'd0) && hpcp.event_vld[hpcp.event_sel]
                  && !hpcp.cnt_inhibit;
  end

  // Stage 2: increment with same-cycle carry; a written half takes the write
  // data, and a written low half blocks the carry into the high half.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_lo_d = cnt_lo_q;
    cnt_hi_d = cnt_hi_q;
    lo_sum   = {1'b0, cnt_lo_q} + {{HW{1'b0}}, event_hit_q};
    lo_carry = lo_sum[HW];
    hi_inc   = cnt_hi_q + {{(HW-1){1'b0}}, lo_carry};
    if (hpcp.cnt_lo_wen) cnt_lo_d = hpcp.hpcp_wdata[HW-1:0];
    else                 cnt_lo_d = lo_sum[HW-1:0];
    if (hpcp.cnt_hi_wen)      cnt_hi_d = hpcp.hpcp_wdata[HW-1:0];
    else if (!hpcp.cnt_lo_wen) cnt_hi_d = hi_inc;
  end

  // Pipeline and counter registers.
  // NOTE: asynchronous reset clears the pending hit too, so a reset mid-operation drops it.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      event_hit_q <= 1'b0;
      cnt_lo_q    <= '0;
      cnt_hi_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      event_hit_q <= event_hit_d;
      cnt_lo_q    <= cnt_lo_d;
      cnt_hi_q    <= cnt_hi_d;
    end
  end

  assign hpcp.cnt_value = {cnt_hi_q, cnt_lo_q};

`ifdef PA_HPCP_CNT_OVF_EN
  logic wrap;
  logic cnt_ovf_d, cnt_ovf_q;
  logic cnt_ovf_int_d, cnt_ovf_int_q;

  // Overflow: only a real increment from all-ones with no write counts; a
  // high-half write clears the flag and wins over a simultaneous wrap.
  always_comb begin
    wrap          = event_hit_q && (&cnt_lo_q) && (&cnt_hi_q)
                    && !hpcp.cnt_lo_wen && !hpcp.cnt_hi_wen;
    cnt_ovf_d     = hpcp.cnt_hi_wen ? 1'b0 : (cnt_ovf_q | wrap);
    cnt_ovf_int_d = wrap;
  end

  // Overflow flag and interrupt pulse registers.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      cnt_ovf_q     <= 1'b0;
      cnt_ovf_int_q <= 1'b0;
    end else begin
      cnt_ovf_q     <= cnt_ovf_d;
      cnt_ovf_int_q <= cnt_ovf_int_d;
    end
  end

  assign hpcp.cnt_ovf     = cnt_ovf_q;
  assign hpcp.cnt_ovf_int = cnt_ovf_int_q;
`else
  assign hpcp.cnt_ovf     = 1'b0;
  assign hpcp.cnt_ovf_int = 1'b0;
`endif

endmodule
